tick_gen: RTL and testbench

//  Multi-channel programmable clock-enable generator for the stopwatch datapath.

---
 rtl/tick_gen_pkg.sv | 14 +
 rtl/tick_chan.sv | 61 ++++++
 rtl/tick_gen.sv | 49 ++++
 tb/tb_tick_gen.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the tick_gen clock-enable generator.
package tick_gen_pkg;

  localparam int unsigned CNT_W_DEF     = 24;
  localparam int unsigned DIV_1KHZ_100M = 100_000;
  localparam int unsigned DIV_DISP_100M = 32_768;
  localparam int unsigned DIV_SLOW_100M = 8_388_608;

  // Channel-select width; a single channel still gets a 1-bit select port.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_chan.sv
// One divider slice: counter, runtime divisor, registered tick and square wave.
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int unsigned      CNT_W    = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_DISP_100M)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             clr,
  input  logic             we,
  input  logic [CNT_W-1:0] din,
  output logic             tick,
  output logic             sq
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] div_nxt;
  logic             tick_nxt;
  logic             sq_nxt;

  // Priority: clear, divisor write, hold (stopped or disabled), wrap, count.
  always_comb begin
    cnt_nxt  = cnt;
    div_nxt  = we ? din : div;
    tick_nxt = 1'b0;
    sq_nxt   = sq;
    if (clr) begin
      cnt_nxt = '0;
      sq_nxt  = 1'b0;
    end else if (we) begin
      cnt_nxt = '0;
    end else if (run && (div != '0)) begin
      if (cnt == div - CNT_W'(1)) begin
        cnt_nxt  = '0;
        tick_nxt = 1'b1;
        sq_nxt   = ~sq;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      div  <= DIV_INIT;
      tick <= 1'b0;
      sq   <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      div  <= div_nxt;
      tick <= tick_nxt;
      sq   <= sq_nxt;
    end
  end

endmodule

// File: rtl/tick_gen.sv
// Multi-channel programmable clock-enable generator; one tick_chan per channel.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int unsigned             NUM_CH   = 2,
  parameter int unsigned             CNT_W    = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {CNT_W_DEF'(DIV_SLOW_100M),
                                                 CNT_W_DEF'(DIV_DISP_100M)}
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic                         clr,
  input  logic                         cfg_we,
  input  logic [sel_width(NUM_CH)-1:0] cfg_sel,
  input  logic [CNT_W-1:0]             cfg_div,
  output logic [NUM_CH-1:0]            tick,
  output logic [NUM_CH-1:0]            sq
);

  localparam int unsigned SEL_W = sel_width(NUM_CH);

  logic [NUM_CH-1:0] ch_we;

  // Selects beyond NUM_CH match no channel, so such writes are dropped.
  always_comb begin
    ch_we = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      ch_we[i] = cfg_we && (cfg_sel == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    tick_chan #(
      .CNT_W    (CNT_W),
      .DIV_INIT (DIV_INIT[g*CNT_W +: CNT_W])
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .run   (run),
      .clr   (clr),
      .we    (ch_we[g]),
      .din   (cfg_div),
      .tick  (tick[g]),
      .sq    (sq[g])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// Scoreboard bench for tick_gen: enabled-edge counting model vs. DUT tick/sq.
module tb_tick_gen;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned SEL_W  = 2;
  localparam logic [NUM_CH*CNT_W-1:0] DIV_INIT = {8'd3, 8'd7, 8'd4};

  logic              clk;
  logic              reset;
  logic              run;
  logic              clr;
  logic              cfg_we;
  logic [SEL_W-1:0]  cfg_sel;
  logic [CNT_W-1:0]  cfg_div;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;

  tick_gen #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .DIV_INIT (DIV_INIT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .clr     (clr),
    .cfg_we  (cfg_we),
    .cfg_sel (cfg_sel),
    .cfg_div (cfg_div),
    .tick    (tick),
    .sq      (sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  event chk_ev;

  // Model: enabled edges since last restart, current divisor, sq phase at restart.
  int   m_div [NUM_CH];
  int   m_n   [NUM_CH];
  logic m_sqb [NUM_CH];

  function automatic logic m_sq(input int i);
    if (m_div[i] == 0) return m_sqb[i];
    return m_sqb[i] ^ (((m_n[i] / m_div[i]) % 2) != 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NUM_CH); i++) begin
      m_div[i] = int'(DIV_INIT[i*CNT_W +: CNT_W]);
      m_n[i]   = 0;
      m_sqb[i] = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic c, input logic w,
                      input logic [SEL_W-1:0] s, input logic [CNT_W-1:0] d);
    exp_t e;
    run = r; clr = c; cfg_we = w; cfg_sel = s; cfg_div = d;
    @(posedge clk);
    e = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      logic hit;
      hit = w && (int'(s) == i);
      if (c) begin
        m_n[i]   = 0;
        m_sqb[i] = 1'b0;
        if (hit) m_div[i] = int'(d);
      end else if (hit) begin
        m_sqb[i] = m_sq(i);
        m_div[i] = int'(d);
        m_n[i]   = 0;
      end else if (r && m_div[i] != 0) begin
        m_n[i]++;
        e.tick[i] = ((m_n[i] % m_div[i]) == 0);
      end
      e.sq[i] = m_sq(i);
    end
    sb_q.push_back(e);
    #2;
  endtask

  task automatic idle(input int cycles, input logic r);
    for (int k = 0; k < cycles; k++) step(r, 1'b0, 1'b0, '0, '0);
  endtask

  // Asserts reset between edges and checks outputs drop without a clock edge.
  task automatic async_reset();
    #4;
    reset = 1'b1;
    model_reset();
    #1;
    sb_q.push_back('0);
    -> chk_ev;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  always begin
    @(negedge clk or chk_ev);
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_tests++;
      if (tick !== mon_e.tick) begin
        n_fail++;
        $display("FAIL tick: got %b expected %b at %0t", tick, mon_e.tick, $time);
      end
      n_tests++;
      if (sq !== mon_e.sq) begin
        n_fail++;
        $display("FAIL sq: got %b expected %b at %0t", sq, mon_e.sq, $time);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; run = 1'b0; clr = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_div = '0;
    model_reset();
    #3;
    sb_q.push_back('0);
    -> chk_ev;
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Reset divisors: ch0=4, ch1=7, ch2=3
    idle(14, 1'b1);
    // ch1 divide-by-one
    step(1'b1, 1'b0, 1'b1, 2'd1, 8'd1);
    idle(10, 1'b1);
    // ch0 disabled, then re-enabled at 3
    step(1'b1, 1'b0, 1'b1, 2'd0, 8'd0);
    idle(100, 1'b1);
    step(1'b1, 1'b0, 1'b1, 2'd0, 8'd3);
    idle(8, 1'b1);
    // Pause mid-period
    step(1'b1, 1'b0, 1'b1, 2'd0, 8'd5);
    idle(2, 1'b1);
    idle(10, 1'b0);
    idle(8, 1'b1);
    // Clear together with a write
    step(1'b1, 1'b1, 1'b1, 2'd0, 8'd6);
    idle(14, 1'b1);
    // Out-of-range select
    step(1'b1, 1'b0, 1'b1, 2'd3, 8'd2);
    idle(10, 1'b1);
    // Asynchronous reset mid-count
    idle(3, 1'b1);
    async_reset();
    idle(15, 1'b1);

    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 99) == 0,
           $urandom_range(0, 29) == 0, SEL_W'($urandom_range(0, 3)),
           CNT_W'($urandom_range(0, 9)));
      if (k % 700 == 699) async_reset();
    end

    idle(1, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
